// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: state codes,
// opcodes and the 2-bit datapath select fields.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd12,
    S_IDLE   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Datapath control bundle produced by the output decoder and consumed by the
// sequencer top.
interface mc_ctrl_if;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_req;
  logic       halted;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic [1:0] alu_src_b;

  modport master (
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, alu_src_a, reg_write, reg_dst, mem_req, halted,
           pc_source, alu_op, alu_src_b
  );

  modport slave (
    input pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
          mem_to_reg, alu_src_a, reg_write, reg_dst, mem_req, halted,
          pc_source, alu_op, alu_src_b
  );
endinterface

// File: rtl/mc_out_decode.sv
// Combinational state-to-control decode. Only the fetch IR/PC strobes look at
// mem_ready, so the PC advances exactly once per completed fetch.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t           state,
  input  logic             mem_ready,
  mc_ctrl_if.master        ctrl
);

  // Per-state control pattern; anything not named for a state stays 0
  always_comb begin
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.i_or_d        = 1'b0;
    ctrl.mem_read      = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.mem_to_reg    = 1'b0;
    ctrl.alu_src_a     = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.reg_dst       = 1'b0;
    ctrl.halted        = 1'b0;
    ctrl.pc_source     = PCS_ALU;
    ctrl.alu_op        = ALU_ADD;
    ctrl.alu_src_b     = SRCB_REG;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SHL;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_HALT:   ctrl.halted    = 1'b1;
      default: begin
      end
    endcase
  end

  assign ctrl.mem_req = ctrl.mem_read | ctrl.mem_write;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle processor control sequencer: Moore FSM, retired-instruction
// counter and the flat control port map.
module mc_sequencer
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_req,
  output logic [1:0]  pc_source,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  state_t      state_r;
  state_t      state_next_s;
  logic        run_en_r;
  logic        retire_s;
  logic [15:0] instr_count_r;

  mc_ctrl_if ctrl ();

  mc_out_decode u_out_decode (
    .state     (state_r),
    .mem_ready (mem_ready),
    .ctrl      (ctrl.master)
  );

  // run_en_r keeps IDLE for one extra edge after reset release
  always_comb begin
    state_next_s = S_IDLE;
    retire_s     = 1'b0;
    case (state_r)
      S_IDLE:   state_next_s = run_en_r ? S_FETCH : S_IDLE;
      S_FETCH:  state_next_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(op)) begin
          state_next_s = S_MEMADR;
        end else begin
          case (op)
            OP_R:    state_next_s = S_EXEC;
            OP_BEQ:  state_next_s = S_BEQ;
            OP_J:    state_next_s = S_JUMP;
            OP_ADDI: state_next_s = S_ADDIEX;
            default: state_next_s = S_HALT;
          endcase
        end
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_next_s = S_MEMRD;
        end else if (op == OP_SW) begin
          state_next_s = S_MEMWR;
        end else begin
          state_next_s = S_HALT;
        end
      end
      S_MEMRD:  state_next_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_next_s = mem_ready ? S_FETCH : S_MEMWR;
        retire_s     = mem_ready;
      end
      S_EXEC:   state_next_s = S_RWB;
      S_ADDIEX: state_next_s = S_ADDIWB;
      S_MEMWB, S_RWB, S_BEQ, S_JUMP, S_ADDIWB: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_HALT:   state_next_s = S_HALT;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // State, start-up gate and retire counter (wraps naturally at 16 bits)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      run_en_r      <= 1'b0;
      instr_count_r <= 16'd0;
    end else begin
      state_r  <= state_next_s;
      run_en_r <= 1'b1;
      if (retire_s) begin
        instr_count_r <= instr_count_r + 16'd1;
      end
    end
  end

  assign state         = state_r;
  assign instr_count   = instr_count_r;
  assign halted        = ctrl.halted;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_req       = ctrl.mem_req;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign alu_src_b     = ctrl.alu_src_b;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: an instruction-path model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  op = 6'd0;
  logic        mem_ready = 1'b0;
  logic [3:0]  state;
  logic [15:0] instr_count;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  mc_ctrl_if cif ();

  mc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .mem_ready     (mem_ready),
    .pc_write      (cif.pc_write),
    .pc_write_cond (cif.pc_write_cond),
    .i_or_d        (cif.i_or_d),
    .mem_read      (cif.mem_read),
    .mem_write     (cif.mem_write),
    .ir_write      (cif.ir_write),
    .mem_to_reg    (cif.mem_to_reg),
    .alu_src_a     (cif.alu_src_a),
    .reg_write     (cif.reg_write),
    .reg_dst       (cif.reg_dst),
    .mem_req       (cif.mem_req),
    .pc_source     (cif.pc_source),
    .alu_op        (cif.alu_op),
    .alu_src_b     (cif.alu_src_b),
    .state         (state),
    .halted        (cif.halted),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  localparam int B_REG_WRITE = 9;
  localparam int B_IR_WRITE  = 12;
  localparam int B_MEM_WRITE = 13;
  localparam int B_I_OR_D    = 15;
  localparam int B_PC_WRITE  = 17;

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {cif.pc_write, cif.pc_write_cond, cif.i_or_d, cif.mem_read,
                     cif.mem_write, cif.ir_write, cif.mem_to_reg, cif.alu_src_a,
                     cif.reg_write, cif.reg_dst, cif.mem_req, cif.halted,
                     cif.pc_source, cif.alu_op, cif.alu_src_b};

  // Each instruction is a fixed walk of state codes starting at FETCH
  function automatic int path_len(input logic [5:0] o);
    case (o)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b001000: return 4;
      default:   return 3;
    endcase
  endfunction

  function automatic int path_at(input logic [5:0] o, input int i);
    int p [0:4];
    case (o)
      6'b000000: p = '{0, 1, 6, 7, 0};
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5, 0};
      6'b000100: p = '{0, 1, 8, 0, 0};
      6'b000010: p = '{0, 1, 9, 0, 0};
      6'b001000: p = '{0, 1, 10, 11, 0};
      default:   p = '{0, 1, 12, 0, 0};
    endcase
    return p[i];
  endfunction

  function automatic logic [17:0] exp_ctrl(input int st, input logic rdy);
    logic pw, pwc, iod, mrd, mw, irw, mtr, asa, rw, rd, hlt;
    logic [1:0] pcs, aop, asb;
    {pw, pwc, iod, mrd, mw, irw, mtr, asa, rw, rd, hlt} = 11'd0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin iod = 1'b1; mrd = 1'b1; end
      4:  begin rw = 1'b1; mtr = 1'b1; end
      5:  begin iod = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; end
      9:  begin pw = 1'b1; pcs = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: rw = 1'b1;
      12: hlt = 1'b1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mw, irw, mtr, asa, rw, rd, (mrd | mw), hlt, pcs, aop, asb};
  endfunction

  // Model: m_mode 0/1 = idle edges after reset, 2 = walking instruction paths
  int          m_mode = 0;
  int          m_idx = 0;
  int          m_retired = 0;
  logic [5:0]  m_op = 6'd0;
  logic [15:0] m_base = 16'd0;
  int          m_cur;
  logic [15:0] m_count;

  assign m_cur   = (m_mode < 2) ? 15 : path_at(m_op, m_idx);
  assign m_count = m_base + m_retired[15:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode    <= 0;
      m_idx     <= 0;
      m_retired <= 0;
    end else if (m_mode < 2) begin
      m_mode <= m_mode + 1;
      m_idx  <= 0;
    end else if (m_cur == 12) begin
    end else if ((m_cur == 0 || m_cur == 3 || m_cur == 5) && !mem_ready) begin
    end else if (m_idx == 1) begin
      m_op  <= op;
      m_idx <= 2;
    end else if (m_idx + 1 < path_len(m_op)) begin
      m_idx <= m_idx + 1;
    end else begin
      m_idx     <= 0;
      m_retired <= m_retired + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_state", {28'd0, state}, m_cur);
      chk("cyc_count", {16'd0, instr_count}, {16'd0, m_count});
      chk("cyc_ctrl", {14'd0, dut_ctrl}, {14'd0, exp_ctrl(m_cur, mem_ready)});
    end
  end

  logic [3:0]  obs_state;
  logic [15:0] obs_count;
  logic [17:0] obs_ctrl;

  task automatic cycle(input logic [5:0] o, input logic rdy);
    op = o;
    mem_ready = rdy;
    @(negedge clk);
    obs_state = state;
    obs_count = instr_count;
    obs_ctrl  = dut_ctrl;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_base = 16'd0;
    op = 6'd0;
    mem_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int t1_seq [0:5];
    int ir_cnt, pw_cnt, wb_edge, halt_cnt;
    logic saw_wr, saw_rw;
    logic [5:0] cur_op;
    logic [5:0] prog [0:5];
    int pi;

    t1_seq = '{15, 0, 1, 6, 7, 0};
    prog   = '{6'b000000, 6'b000100, 6'b001000, 6'b101011, 6'b100011, 6'b000010};

    #1;
    chk_en = 1'b1;
    do_reset();

    // R-type with memory always ready; also pins the two-edge start-up
    for (int i = 1; i <= 7; i++) begin
      cycle(6'b000000, 1'b1);
      if (i >= 2) chk("r_state_seq", {28'd0, obs_state}, t1_seq[i-2]);
    end
    chk("r_count", {16'd0, obs_count}, 32'd1);

    // LW with fetch and read stalls; mem_ready pulses while idle/decoding are ignored
    do_reset();
    ir_cnt = 0; pw_cnt = 0; wb_edge = -1;
    for (int i = 1; i <= 13; i++) begin
      cycle(6'b100011, (i == 1 || i == 2 || i == 6 || i == 7 || i == 8 || i == 11));
      if (obs_ctrl[B_IR_WRITE]) ir_cnt++;
      if (obs_ctrl[B_PC_WRITE] && obs_state == 4'd0) pw_cnt++;
      if (obs_state == 4'd4 && wb_edge < 0) wb_edge = i - 1;
    end
    chk("lw_ir_pulses", ir_cnt, 32'd1);
    chk("lw_pc_pulses", pw_cnt, 32'd1);
    chk("lw_memwb_edge", wb_edge, 32'd11);
    chk("lw_count", {16'd0, obs_count}, 32'd1);

    // SW
    do_reset();
    saw_wr = 1'b0; saw_rw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle(6'b101011, 1'b1);
      if (obs_state == 4'd5 && obs_ctrl[B_MEM_WRITE] && obs_ctrl[B_I_OR_D]) saw_wr = 1'b1;
      if (obs_ctrl[B_REG_WRITE]) saw_rw = 1'b1;
    end
    chk("sw_write_seen", {31'd0, saw_wr}, 32'd1);
    chk("sw_no_reg_write", {31'd0, saw_rw}, 32'd0);
    chk("sw_count", {16'd0, obs_count}, 32'd1);

    // Illegal opcode parks in HALT whatever happens on op/mem_ready
    do_reset();
    halt_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i <= 4) cycle(6'b111111, 1'b1);
      else cycle(6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)));
      if (i == 4) chk("ill_decode", {28'd0, obs_state}, 32'd1);
      if (i == 5) chk("ill_halt", {28'd0, obs_state}, 32'd12);
      if (i >= 6 && obs_state == 4'd12 && obs_ctrl[6]) halt_cnt++;
    end
    chk("ill_halt_cycles", halt_cnt, 32'd20);

    // Mixed program; op is garbage outside DECODE/MEMADR
    do_reset();
    pi = 0;
    cur_op = 6'b111111;
    for (int i = 1; i <= 26; i++) begin
      if (m_cur == 0) begin
        cur_op = (pi < 6) ? prog[pi] : 6'b000000;
        pi++;
      end else if (m_cur != 1 && m_cur != 2) begin
        cur_op = 6'b111111;
      end
      cycle(cur_op, 1'b1);
    end
    chk("prog_count", {16'd0, obs_count}, 32'd6);
    chk("prog_state", {28'd0, obs_state}, 32'd0);

    // Reset asserted while stalled in MEMRD
    do_reset();
    for (int i = 1; i <= 13; i++) cycle(6'b100011, (i <= 10));
    chk("rd_stall_state", {28'd0, obs_state}, 32'd3);
    chk("rd_stall_count", {16'd0, obs_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_state", {28'd0, state}, 32'd15);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    chk("rst_ctrl", {14'd0, dut_ctrl}, 32'd0);

    // Jumps, counter preset near the top to exercise the wrap
    do_reset();
    for (int i = 1; i <= 18; i++) cycle(6'b000010, (i <= 17));
    chk("j_count5", {16'd0, obs_count}, 32'd5);
    force dut.instr_count_r = 16'hFFFC;
    m_base = 16'hFFF7;
    cycle(6'b000010, 1'b0);
    release dut.instr_count_r;
    for (int i = 20; i <= 35; i++) begin
      cycle(6'b000010, 1'b1);
      if (i == 29) chk("j_count_ffff", {16'd0, obs_count}, 32'h0000FFFF);
      if (i == 32) chk("j_count_wrap", {16'd0, obs_count}, 32'd0);
      if (i == 35) chk("j_count_after", {16'd0, obs_count}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, rising-edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: op  input  6  opcode field of the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  memory completion strobe, sampled only while mem_req=1.
REQ-005 SHALL have ports, all output 1: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst, mem_req (= mem_read|mem_write).
REQ-006 SHALL have ports, all output 2: pc_source, alu_op, alu_src_b.
REQ-007 SHALL have port: state  output  4  current state code, for debug.
REQ-008 SHALL have port: halted  output  1  set when an illegal opcode is decoded.
REQ-009 SHALL have port: instr_count  output  16  count of retired instructions.

Function
REQ-010 SHALL implement a registered Moore FSM with these codes: IDLE=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12.
REQ-011 SHALL decode these opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000; every other opcode SHALL be illegal.
REQ-012 SHALL go IDLE->FETCH unconditionally, and all control outputs SHALL be 0 in IDLE.
REQ-013 SHALL hold FETCH while mem_ready=0; mem_ready=1 goes to DECODE.
REQ-014 FETCH SHALL drive mem_read=1 and alu_src_b=01 on every cycle; ir_write=1 and pc_write=1 SHALL be asserted only on the cycle mem_ready=1, so PC advances exactly once per fetch.
REQ-015 DECODE SHALL drive alu_src_b=11 and go to: LW/SW->MEMADR, R->EXEC, BEQ->BEQ, J->JUMP, ADDI->ADDIEX, illegal->HALT.
REQ-016 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, and go LW->MEMRD, SW->MEMWR.
REQ-017 MEMRD SHALL drive i_or_d=1 and mem_read=1, and SHALL hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-019 MEMWR SHALL drive i_or_d=1 and mem_write=1, and SHALL hold until mem_ready=1, then go to FETCH.
REQ-020 EXEC SHALL drive alu_src_a=1, alu_op=10, then go to RWB.
REQ-021 RWB SHALL drive reg_write=1, reg_dst=1, then go to FETCH.
REQ-022 BEQ SHALL drive alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-023 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-024 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB.
REQ-025 ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-026 HALT SHALL be absorbing until reset, drive all control outputs 0, and hold halted=1.
REQ-027 Any control output not listed for a state SHALL be 0 in that state.
REQ-028 op SHALL be sampled only in DECODE and MEMADR; changes on op in any other state SHALL have no effect.
REQ-029 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BEQ, JUMP or ADDIWB, and SHALL wrap from 0xFFFF to 0x0000.
REQ-030 mem_ready asserted while mem_req=0 SHALL be ignored.
REQ-031 An undefined state code SHALL recover to IDLE on the next clock.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, halted=0, instr_count=0, and all control outputs 0, including reset asserted mid-stall.
REQ-033 After rst_n rises, the first FETCH SHALL begin on the second rising clock edge.

Structure
REQ-034 State codes, opcode constants and the 2-bit alu_op/alu_src_b/pc_source encodings SHALL live in the shared package mc_pkg.
REQ-035 SHALL contain one sub-module mc_out_decode: purely combinational, state -> control outputs.
REQ-036 The next-state logic and the registers SHALL reside in mc_sequencer.

Verification
REQ-037 Reset release, mem_ready=1 constantly, op=000000 -> states 15,0,1,6,7,0; instr_count=1.
REQ-038 op=100011, mem_ready low 3 cycles in FETCH and 2 cycles in MEMRD -> ir_write pulses once, pc_write pulses once in FETCH, MEMWB reached 11 edges after reset release.
REQ-039 op=101011 -> mem_write=1 and i_or_d=1 in state 5, reg_write never 1, instr_count increments by 1.
REQ-040 op=111111 -> state 1 then 12, halted=1, and state stays 12 for 20 cycles despite op/mem_ready changes.
REQ-041 65536 J instructions -> instr_count returns to 0x0000; pc_source=10 in every JUMP cycle.
REQ-042 rst_n=0 asserted while stalled in MEMRD -> outputs 0 in the same cycle, state=15, instr_count=0.
